// File: rtl/eer_pkg.sv
// Shared packet definitions for the EER radio transmit/receive paths.
// Packet types, per-type word counts and payload field selectors.
package eer_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int SEQ_WIDTH  = 8;
  localparam int LEN_WIDTH  = 5;

  typedef enum logic [2:0] {
    PKT_RSVD0 = 3'd0,
    PKT_HB    = 3'd1,
    PKT_CHE   = 3'd2,
    PKT_INV   = 3'd3,
    PKT_CHT   = 3'd4,
    PKT_DATA  = 3'd5,
    PKT_ACK   = 3'd6,
    PKT_RSVD7 = 3'd7
  } pkt_type_e;

  // Total words on the wire, header included.
  localparam logic [LEN_WIDTH-1:0] LEN_HB   = 5'd5;
  localparam logic [LEN_WIDTH-1:0] LEN_CHE  = 5'd6;
  localparam logic [LEN_WIDTH-1:0] LEN_INV  = 5'd5;
  localparam logic [LEN_WIDTH-1:0] LEN_CHT  = 5'd3;
  localparam logic [LEN_WIDTH-1:0] LEN_DATA = 5'd8;
  localparam logic [LEN_WIDTH-1:0] LEN_ACK  = 5'd3;

  typedef enum logic [2:0] {
    F_SRC    = 3'd0,
    F_DEST   = 3'd1,
    F_HOPS   = 3'd2,
    F_Q      = 3'd3,
    F_E      = 3'd4,
    F_CH     = 3'd5,
    F_CHHOPS = 3'd6
  } field_sel_e;

endpackage

// File: rtl/packet_tx_layout.sv
// Combinational packet layout: (type, word index) -> payload field, length, type validity.
// Word 0 is the header and is built by the caller; index 1 is always the source ID.
module packet_tx_layout
  import eer_pkg::*;
(
  input  logic [2:0]           pkt_type,
  input  logic [LEN_WIDTH-1:0] idx,
  output field_sel_e           fsel,
  output logic [LEN_WIDTH-1:0] len,
  output logic                 valid_type
);

  always_comb begin
    fsel       = F_SRC;
    len        = '0;
    valid_type = 1'b1;
    case (pkt_type_e'(pkt_type))
      PKT_HB: begin
        len = LEN_HB;
        case (idx)
          5'd2:    fsel = F_HOPS;
          5'd3:    fsel = F_Q;
          5'd4:    fsel = F_E;
          default: fsel = F_SRC;
        endcase
      end
      PKT_CHE: begin
        len = LEN_CHE;
        case (idx)
          5'd2:    fsel = F_HOPS;
          5'd3:    fsel = F_Q;
          5'd4:    fsel = F_E;
          5'd5:    fsel = F_CH;
          default: fsel = F_SRC;
        endcase
      end
      PKT_INV: begin
        len = LEN_INV;
        case (idx)
          5'd2:    fsel = F_DEST;
          5'd3:    fsel = F_CH;
          5'd4:    fsel = F_CHHOPS;
          default: fsel = F_SRC;
        endcase
      end
      PKT_CHT: begin
        len = LEN_CHT;
        case (idx)
          5'd2:    fsel = F_CH;
          default: fsel = F_SRC;
        endcase
      end
      PKT_DATA: begin
        len = LEN_DATA;
        case (idx)
          5'd2:    fsel = F_DEST;
          5'd3:    fsel = F_HOPS;
          5'd4:    fsel = F_Q;
          5'd5:    fsel = F_E;
          5'd6:    fsel = F_CH;
          5'd7:    fsel = F_CHHOPS;
          default: fsel = F_SRC;
        endcase
      end
      PKT_ACK: begin
        len = LEN_ACK;
        case (idx)
          5'd2:    fsel = F_DEST;
          default: fsel = F_SRC;
        endcase
      end
      default: valid_type = 1'b0;
    endcase
  end

endmodule

// File: rtl/packet_tx.sv
// Packet serializer: captures r* fields on en, emits header + typed payload as 16-bit words.
// Header one cycle after en; one word per cycle while txReady; holds word while txReady low.
module packet_tx #(
  parameter int WORD_WIDTH = 16,
  parameter int SEQ_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [2:0]            rPacketType,
  input  logic [WORD_WIDTH-1:0] rSourceID,
  input  logic [WORD_WIDTH-1:0] rDestinationID,
  input  logic [WORD_WIDTH-1:0] rSourceHops,
  input  logic [WORD_WIDTH-1:0] rQValue,
  input  logic [WORD_WIDTH-1:0] rEnergyLeft,
  input  logic [WORD_WIDTH-1:0] rChosenCH,
  input  logic [WORD_WIDTH-1:0] rHopsFromCH,
  output logic [WORD_WIDTH-1:0] txData,
  output logic                  txValid,
  input  logic                  txReady,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  rejected
);
  import eer_pkg::*;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_e;

  state_e                 state, state_next;
  logic [2:0]             type_q;
  logic [LEN_WIDTH-1:0]   idx, len_q;
  logic [SEQ_WIDTH-1:0]   seq, hdr_seq;
  logic [WORD_WIDTH-1:0]  src_q, dest_q, hops_q, q_q, e_q, ch_q, chhops_q;
  logic [WORD_WIDTH-1:0]  data_q, next_field;
  logic                   rejected_q;

  logic [2:0]             lut_type;
  logic [LEN_WIDTH-1:0]   lut_idx, lut_len;
  field_sel_e             lut_fsel;
  logic                   lut_valid;
  logic                   can_start, start, reject, fire, last;

  // While sending, look up the word after the current one; otherwise classify the incoming type.
  always_comb begin
    lut_type = rPacketType;
    lut_idx  = '0;
    if (state == S_SEND) begin
      lut_type = type_q;
      lut_idx  = idx + 1'b1;
    end
  end

  packet_tx_layout u_layout (
    .pkt_type   (lut_type),
    .idx        (lut_idx),
    .fsel       (lut_fsel),
    .len        (lut_len),
    .valid_type (lut_valid)
  );

  // DONE accepts a new start so back-to-back packets only lose one cycle.
  assign can_start = (state == S_IDLE) || (state == S_DONE);
  assign start     = can_start && en && lut_valid;
  assign reject    = can_start && en && !lut_valid;
  assign fire      = (state == S_SEND) && txReady;
  assign last      = (idx == len_q - 1'b1);
  assign hdr_seq   = (state == S_DONE) ? seq + 1'b1 : seq;

  always_comb begin
    next_field = src_q;
    case (lut_fsel)
      F_SRC:    next_field = src_q;
      F_DEST:   next_field = dest_q;
      F_HOPS:   next_field = hops_q;
      F_Q:      next_field = q_q;
      F_E:      next_field = e_q;
      F_CH:     next_field = ch_q;
      F_CHHOPS: next_field = chhops_q;
      default:  next_field = src_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_SEND;
      S_SEND:  if (fire && last) state_next = S_DONE;
      S_DONE:  state_next = start ? S_SEND : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      type_q     <= '0;
      idx        <= '0;
      len_q      <= '0;
      seq        <= '0;
      src_q      <= '0;
      dest_q     <= '0;
      hops_q     <= '0;
      q_q        <= '0;
      e_q        <= '0;
      ch_q       <= '0;
      chhops_q   <= '0;
      data_q     <= '0;
      rejected_q <= 1'b0;
    end else begin
      rejected_q <= reject;
      if (state == S_DONE) seq <= seq + 1'b1;
      if (start) begin
        type_q   <= rPacketType;
        len_q    <= lut_len;
        idx      <= '0;
        src_q    <= rSourceID;
        dest_q   <= rDestinationID;
        hops_q   <= rSourceHops;
        q_q      <= rQValue;
        e_q      <= rEnergyLeft;
        ch_q     <= rChosenCH;
        chhops_q <= rHopsFromCH;
        data_q   <= WORD_WIDTH'({rPacketType, lut_len, hdr_seq});
      end else if (fire) begin
        if (last) begin
          idx    <= '0;
          data_q <= '0;
        end else begin
          idx    <= idx + 1'b1;
          data_q <= next_field;
        end
      end
    end
  end

  assign txData   = data_q;
  assign txValid  = (state == S_SEND);
  assign busy     = (state != S_IDLE);
  assign tx_done  = (state == S_DONE);
  assign rejected = rejected_q;

endmodule

// File: tb/tb_packet_tx.sv
// Randomized bench for packet_tx against a queue-based packet model.
module tb_packet_tx;

  logic        clk = 1'b0;
  logic        nrst, en, txReady;
  logic [2:0]  rPacketType;
  logic [15:0] rSourceID, rDestinationID, rSourceHops, rQValue, rEnergyLeft, rChosenCH, rHopsFromCH;
  logic [15:0] txData;
  logic        txValid, busy, tx_done, rejected;

  always #5 clk = ~clk;

  packet_tx dut (
    .clk(clk), .nrst(nrst), .en(en), .rPacketType(rPacketType),
    .rSourceID(rSourceID), .rDestinationID(rDestinationID), .rSourceHops(rSourceHops),
    .rQValue(rQValue), .rEnergyLeft(rEnergyLeft), .rChosenCH(rChosenCH), .rHopsFromCH(rHopsFromCH),
    .txData(txData), .txValid(txValid), .txReady(txReady),
    .busy(busy), .tx_done(tx_done), .rejected(rejected)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int model_seq = 0;
  logic [15:0] fv[7];          // src, dest, hops, Q, E, chosenCH, hopsFromCH
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int first_cyc, done_cyc, stalls, hold_err, busy_err, rej_err;
  bit timeout;

  function automatic void build_expected(input int t);
    int pl[$];
    logic [2:0] tt;
    logic [4:0] ll;
    logic [7:0] ss;
    case (t)
      1: pl = '{0, 2, 3, 4};
      2: pl = '{0, 2, 3, 4, 5};
      3: pl = '{0, 1, 5, 6};
      4: pl = '{0, 5};
      5: pl = '{0, 1, 2, 3, 4, 5, 6};
      6: pl = '{0, 1};
      default: pl = '{};
    endcase
    tt = t[2:0];
    ll = 5'(pl.size() + 1);
    ss = model_seq[7:0];
    exp_q.delete();
    exp_q.push_back({tt, ll, ss});
    foreach (pl[i]) exp_q.push_back(fv[pl[i]]);
  endfunction

  task automatic drive_fields();
    rSourceID = fv[0]; rDestinationID = fv[1]; rSourceHops = fv[2]; rQValue = fv[3];
    rEnergyLeft = fv[4]; rChosenCH = fv[5]; rHopsFromCH = fv[6];
  endtask

  task automatic scramble_inputs();
    rSourceID = 16'($urandom); rDestinationID = 16'($urandom); rSourceHops = 16'($urandom);
    rQValue = 16'($urandom); rEnergyLeft = 16'($urandom); rChosenCH = 16'($urandom);
    rHopsFromCH = 16'($urandom); rPacketType = 3'($urandom);
  endtask

  task automatic random_fields();
    foreach (fv[i]) fv[i] = 16'($urandom);
  endtask

  // Launches one packet and records what the DUT emits; stall_word forces 3 stall cycles on that word.
  task automatic xmit(input int t, input int stall_pct, input int stall_word, input bit inject_en);
    bit ready, prev_stall;
    logic [15:0] prev_data;
    int forced;
    got_q.delete();
    stalls = 0; hold_err = 0; busy_err = 0; rej_err = 0; timeout = 0;
    first_cyc = -1; done_cyc = -1; prev_stall = 0; prev_data = '0; forced = 0;
    @(negedge clk);
    rPacketType = t[2:0]; drive_fields(); en = 1'b1; txReady = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      scramble_inputs();
      en = inject_en && (cyc == 2);
      if (en) rPacketType = 3'($urandom_range(6, 1));
      if (prev_stall && (txData !== prev_data || txValid !== 1'b1)) hold_err++;
      if (busy !== 1'b1) busy_err++;
      if (rejected !== 1'b0) rej_err++;
      if (tx_done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (txValid === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        ready = ($urandom_range(99) >= stall_pct);
        if (got_q.size() == stall_word && forced < 3) begin
          ready = 1'b0;
          forced++;
        end
        txReady = ready;
        if (ready) got_q.push_back(txData);
        else stalls++;
        prev_stall = !ready;
        prev_data = txData;
      end else begin
        txReady = 1'b1;
        prev_stall = 1'b0;
      end
      @(negedge clk);
    end
    en = 1'b0; txReady = 1'b1;
    if (done_cyc < 0) timeout = 1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; en = 1'b0; txReady = 1'b1; rPacketType = '0;
    random_fields(); drive_fields();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({txData, txValid, busy, tx_done, rejected} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got data=%h vld=%b busy=%b done=%b rej=%b, want all 0",
               txData, txValid, busy, tx_done, rejected);
    end
    nrst = 1'b1;
    model_seq = 0;
  endtask

  task automatic test_hb_directed();
    fv = '{16'h000C, 16'h0000, 16'h0001, 16'h0200, 16'h8000, 16'h0000, 16'h0000};
    build_expected(1);
    xmit(1, 0, -1, 0);
    n_cmp++;
    if (got_q.size() != 5 || got_q[0] !== 16'h2500 || got_q != exp_q) begin
      n_bad++;
      $display("FAIL hb_words: got %0d words first=%h, want 5 words first=2500 (%p)", got_q.size(),
               got_q.size() > 0 ? got_q[0] : 16'hxxxx, exp_q);
    end
    n_cmp++;
    if (timeout || first_cyc != 1 || done_cyc != 6 || busy_err != 0) begin
      n_bad++;
      $display("FAIL hb_timing: got first=%0d done=%0d busy_err=%0d, want 1 6 0", first_cyc, done_cyc, busy_err);
    end
    model_seq = (model_seq + 1) % 256;
    @(negedge clk);
    n_cmp++;
    if (tx_done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL done_pulse: got tx_done=%b busy=%b after DONE, want 0 0", tx_done, busy);
    end
  endtask

  task automatic test_data();
    random_fields();
    fv[0] = 16'h000C; fv[1] = 16'h0003;
    build_expected(5);
    xmit(5, 0, -1, 0);
    n_cmp++;
    if (timeout || got_q != exp_q || done_cyc != 9) begin
      n_bad++;
      $display("FAIL data_pkt: got %p done=%0d, want %p done=9", got_q, done_cyc, exp_q);
    end
    model_seq = (model_seq + 1) % 256;
  endtask

  task automatic test_backpressure();
    random_fields();
    fv[0] = 16'h000C;
    build_expected(4);
    xmit(4, 0, 1, 0);
    n_cmp++;
    if (timeout || got_q != exp_q) begin
      n_bad++;
      $display("FAIL bp_words: got %p, want %p", got_q, exp_q);
    end
    n_cmp++;
    if (stalls != 3 || hold_err != 0 || done_cyc != 7) begin
      n_bad++;
      $display("FAIL bp_hold: got stalls=%0d hold_err=%0d done=%0d, want 3 0 7", stalls, hold_err, done_cyc);
    end
    model_seq = (model_seq + 1) % 256;
  endtask

  task automatic test_rejected();
    int bad_types[2] = '{0, 7};
    foreach (bad_types[k]) begin
      @(negedge clk);
      rPacketType = bad_types[k][2:0]; en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      n_cmp++;
      if (rejected !== 1'b1 || txValid !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reject_pulse: type %0d got rej=%b vld=%b busy=%b, want 1 0 0",
                 bad_types[k], rejected, txValid, busy);
      end
      @(negedge clk);
      n_cmp++;
      if (rejected !== 1'b0 || txValid !== 1'b0) begin
        n_bad++;
        $display("FAIL reject_len: type %0d got rej=%b vld=%b next cycle, want 0 0", bad_types[k], rejected, txValid);
      end
    end
    random_fields();
    build_expected(1);
    xmit(1, 0, -1, 0);
    n_cmp++;
    if (timeout || got_q != exp_q) begin
      n_bad++;
      $display("FAIL reject_seq: got %p, want %p", got_q, exp_q);
    end
    model_seq = (model_seq + 1) % 256;
  endtask

  task automatic test_ignore_en();
    for (int n = 0; n < 4; n++) begin
      int t = $urandom_range(6, 1);
      random_fields();
      build_expected(t);
      xmit(t, 20, -1, 1);
      n_cmp++;
      if (timeout || got_q != exp_q || hold_err != 0 || rej_err != 0) begin
        n_bad++;
        $display("FAIL ignore_en: type %0d got %p hold_err=%0d rej_err=%0d, want %p", t, got_q, hold_err, rej_err, exp_q);
      end
      model_seq = (model_seq + 1) % 256;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      int t = $urandom_range(6, 1);
      int pct = $urandom_range(50);
      random_fields();
      build_expected(t);
      xmit(t, pct, -1, 0);
      n_cmp++;
      if (timeout || got_q != exp_q || hold_err != 0 || busy_err != 0 ||
          done_cyc != exp_q.size() + 1 + stalls) begin
        n_bad++;
        $display("FAIL random_pkt: type %0d got %p done=%0d stalls=%0d hold_err=%0d, want %p",
                 t, got_q, done_cyc, stalls, hold_err, exp_q);
      end
      model_seq = (model_seq + 1) % 256;
    end
  endtask

  task automatic test_reset_mid();
    int stray_done = 0;
    random_fields();
    @(negedge clk);
    rPacketType = 3'd3; drive_fields(); en = 1'b1; txReady = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({txData, txValid, busy, tx_done, rejected} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_mid: got data=%h vld=%b busy=%b done=%b rej=%b, want all 0",
               txData, txValid, busy, tx_done, rejected);
    end
    nrst = 1'b1;
    model_seq = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_done === 1'b1 || txValid === 1'b1) stray_done++;
    end
    n_cmp++;
    if (stray_done != 0) begin
      n_bad++;
      $display("FAIL reset_drop: got %0d cycles of activity after reset, want 0", stray_done);
    end
    random_fields();
    build_expected(1);
    xmit(1, 0, -1, 0);
    n_cmp++;
    if (timeout || got_q.size() == 0 || got_q[0] !== 16'h2500 || got_q != exp_q) begin
      n_bad++;
      $display("FAIL reset_seq: got %p, want %p with header 2500", got_q, exp_q);
    end
    model_seq = (model_seq + 1) % 256;
  endtask

  task automatic test_seq_wrap();
    for (int n = 0; n < 256; n++) begin
      random_fields();
      build_expected(6);
      xmit(6, 0, -1, 0);
      n_cmp++;
      if (timeout || got_q != exp_q) begin
        n_bad++;
        $display("FAIL seq_wrap: packet %0d got %p, want %p", n, got_q, exp_q);
      end
      model_seq = (model_seq + 1) % 256;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_hb_directed();
    test_data();
    test_backpressure();
    test_rejected();
    test_ignore_en();
    test_random();
    test_reset_mid();
    test_seq_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
